irq_controller: RTL and testbench

Parametrised interrupt controller that replaces the four fixed, direct-wired CPU interrupt lines with NUM_IRQ maskable, prioritised channels. It sits between the peripheral interrupt sources (timers, UART RX, frame-drawn, external pins) and the CPU. It synchronises each source and latches edge events into pending bits. It presents a single registered request plus the winning channel ID, and exposes a small register window to the MemoryUnit.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_sync.sv | 37 +++
 rtl/irq_controller.sv | 128 ++++++++++++
 tb/tb_irq_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   - Register indices for the MemoryUnit register window.
//   - lowest_set(): fixed-priority encoder, index 0 wins.
package irq_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_RAISE   = 2'd3;

    // Returns the index of the lowest set bit of v, or 0 when v is all
    // zero (callers qualify the result with |v).
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// One interrupt channel front end: optional polarity inversion, a
// SYNC_STAGES-deep synchroniser and a previous-value flop for rise detect.
// Ports:
//   clk, nreset  clock and asynchronous active-low reset
//   irq_raw      raw source, asynchronous to clk
//   level        synchronised, polarity-corrected level
//   rise         one-cycle pulse on a 0->1 change of level
module irq_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic nreset,
    input  logic irq_raw,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw ^ ACTIVE_LOW};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    // prev resets to 0, so a source already active at reset release
    // still produces one rise once the synchroniser has filled.
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Prioritised, maskable interrupt controller.
// Ports:
//   clk, nreset        clock and asynchronous active-low reset
//   irq_in             raw interrupt sources (asynchronous)
//   sel/we/addr/wdata  register access strobe, write enable, index, data
//   rdata              registered read data
//   int_out, int_id    registered request and winning channel to the CPU
//   ack                one-cycle acknowledge of int_id
//
// Handshakes: a register access is a single-cycle sel pulse (we selects
// write); read data appears on rdata the cycle after sel and holds until the
// next read. int_out/int_id form a level request; the CPU answers with a
// one-cycle ack that applies to the int_id shown in that cycle, and ack while
// int_out is low is ignored.
module irq_controller
    import irq_pkg::*;
#(
    parameter int                 NUM_IRQ         = 8,
    parameter int                 SYNC_STAGES     = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK       = '1,
    parameter logic [NUM_IRQ-1:0] ACTIVE_LOW_MASK = '0,
    parameter int                 ID_W            = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               sel,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               int_out,
    output logic [ID_W-1:0]    int_id,
    input  logic               ack
);

    logic [NUM_IRQ-1:0] sync_level;
    logic [NUM_IRQ-1:0] sync_rise;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] set_vec, clr_vec, req;
    logic [31:0]        rdata_d;
    logic [4:0]         prio_idx;
    logic [ID_W-1:0]    int_id_d;
    logic               wr_en;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
        irq_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .ACTIVE_LOW  (ACTIVE_LOW_MASK[g])
        ) u_sync (
            .clk     (clk),
            .nreset  (nreset),
            .irq_raw (irq_in[g]),
            .level   (sync_level[g]),
            .rise    (sync_rise[g])
        );
    end

    assign wr_en = sel & we;

    // Next pending/enable state. Sets are OR-ed after clears so a rise or
    // RAISE coinciding with an ack or W1C never loses the event. Level
    // channels simply follow their synchronised input.
    always_comb begin
        set_vec  = sync_rise;
        clr_vec  = '0;
        enable_d = enable_q;
        if (ack && int_out) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (int_id == ID_W'(i)) begin
                    clr_vec[i] = 1'b1;
                end
            end
        end
        if (wr_en && (addr == REG_PENDING)) begin
            clr_vec = clr_vec | wdata[NUM_IRQ-1:0];
        end
        if (wr_en && (addr == REG_RAISE)) begin
            set_vec = set_vec | wdata[NUM_IRQ-1:0];
        end
        if (wr_en && (addr == REG_ENABLE)) begin
            enable_d = wdata[NUM_IRQ-1:0];
        end
        pending_d = (EDGE_MASK & ((pending_q & ~clr_vec) | set_vec))
                  | (~EDGE_MASK & sync_level);
    end

    // Output request is computed from the registered pending/enable, so it
    // trails pending by one cycle.
    always_comb begin
        req      = pending_q & enable_q;
        prio_idx = lowest_set(32'(req));
        int_id_d = ID_W'(prio_idx);
    end

    always_comb begin
        rdata_d = '0;
        case (addr)
            REG_PENDING: rdata_d[NUM_IRQ-1:0] = pending_q;
            REG_ENABLE:  rdata_d[NUM_IRQ-1:0] = enable_q;
            REG_STATUS: begin
                rdata_d[31]       = int_out;
                rdata_d[ID_W-1:0] = int_id;
            end
            default:     rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pending_q <= '0;
            enable_q  <= '0;
            int_out   <= 1'b0;
            int_id    <= '0;
            rdata     <= '0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            int_out   <= |req;
            int_id    <= int_id_d;
            if (sel && !we) begin
                rdata <= rdata_d;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam int         N      = 8;
    localparam int         S      = 2;
    localparam int         IDW    = 3;
    localparam logic [7:0] EDGE   = 8'hFE;
    localparam logic [7:0] ALOW   = 8'h01;
    localparam int         MAXC   = 20000;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           nreset;
    logic [N-1:0]   irq_in;
    logic           sel, we, ack;
    logic [1:0]     addr;
    logic [31:0]    wdata, rdata;
    logic           int_out;
    logic [IDW-1:0] int_id;

    always #5 clk = ~clk;

    irq_controller #(
        .NUM_IRQ         (N),
        .SYNC_STAGES     (S),
        .EDGE_MASK       (EDGE),
        .ACTIVE_LOW_MASK (ALOW),
        .ID_W            (IDW)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .irq_in  (irq_in),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .int_out (int_out),
        .int_id  (int_id),
        .ack     (ack)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int passes = 0;
    logic [31:0]  exp_q[$];      // expected rdata after each read
    logic [IDW:0] exp_irq_q[$];  // expected {int_out, int_id} per clock edge

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Works from the documented latencies: the synchroniser output after
    // edge c equals the polarity-corrected input sampled at edge c-S+1, or 0
    // if that sample predates reset release.
    logic [N-1:0] samp[MAXC];
    int           cyc = 0;
    int           first_valid = 1;
    logic [N-1:0] m_pend = '0, m_en = '0;
    logic         m_out = 1'b0;
    logic [IDW-1:0] m_id = '0;

    function automatic logic [N-1:0] lvl(input int c);
        int src;
        src = c - S + 1;
        if (src < first_valid || src < 0) return '0;
        return samp[src];
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] rise_v, cur_lvl, clr, set, req;
        logic         n_out;
        logic [IDW-1:0] n_id;
        logic [31:0]  rd;
        cyc++;
        if (!nreset) begin
            m_pend = '0; m_en = '0; m_out = 1'b0; m_id = '0;
            first_valid = cyc + 1;
            exp_irq_q.push_back('0);
        end else begin
            if (cyc < MAXC) samp[cyc] = irq_in ^ ALOW;
            cur_lvl = lvl(cyc - 1);
            rise_v  = cur_lvl & ~lvl(cyc - 2);
            // outputs and read data come from the state before this edge
            req   = m_pend & m_en;
            n_out = (req != '0);
            n_id  = '0;
            for (int i = N - 1; i >= 0; i--) if (req[i]) n_id = IDW'(i);
            if (sel && !we) begin
                case (addr)
                    2'd0:    rd = 32'(m_pend);
                    2'd1:    rd = 32'(m_en);
                    2'd2:    rd = {m_out, 28'd0, m_id};
                    default: rd = 32'd0;
                endcase
                exp_q.push_back(rd);
            end
            clr = '0;
            set = rise_v;
            if (ack && m_out) clr[m_id] = 1'b1;
            if (sel && we && addr == 2'd0) clr = clr | wdata[N-1:0];
            if (sel && we && addr == 2'd3) set = set | wdata[N-1:0];
            if (sel && we && addr == 2'd1) m_en = wdata[N-1:0];
            m_pend = (EDGE & ((m_pend & ~clr) | set)) | (~EDGE & cur_lvl);
            m_out = n_out;
            m_id  = n_id;
            exp_irq_q.push_back({m_out, m_id});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [IDW:0] e;
        logic [31:0]  r;
        while (exp_irq_q.size() > 0) begin
            e = exp_irq_q.pop_front();
            check("irq_out_id", 32'({int_out, int_id}), 32'(e));
        end
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check("rdata", rdata, r);
        end
    end

    // ---------------- driver tasks (called just after a negedge) ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        d = rdata;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        nreset = 1'b0; irq_in = 8'h01; sel = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; ack = 1'b0;
        wait_cyc(3);
        check("reset_int_out", 32'(int_out), 32'd0);
        check("reset_int_id", 32'(int_id), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        nreset = 1'b1;
        wait_cyc(S + 2);

        // masked edge channel: pending latches but no request
        irq_in[3] = 1'b1; wait_cyc(3);
        irq_in[3] = 1'b0; wait_cyc(S + 3);
        check("masked_int_out", 32'(int_out), 32'd0);
        read_reg(2'd0, rd);
        check("masked_pending", rd, 32'h08);
        write_reg(2'd0, 32'hFF);

        // latency and priority
        write_reg(2'd1, 32'hFF);
        irq_in[5] = 1'b1; irq_in[2] = 1'b1;
        wait_cyc(S + 1);
        check("latency_not_yet", 32'(int_out), 32'd0);
        wait_cyc(1);
        check("latency_int_out", 32'(int_out), 32'd1);
        check("prio_id2", 32'(int_id), 32'd2);
        pulse_ack(); wait_cyc(1);
        check("after_ack_id5", 32'({int_out, int_id}), 32'({1'b1, 3'd5}));
        pulse_ack(); wait_cyc(1);
        check("after_ack2_out", 32'(int_out), 32'd0);

        // set/clear collision on channel 2
        irq_in[5] = 1'b0; irq_in[2] = 1'b0; wait_cyc(4);
        irq_in[2] = 1'b1; wait_cyc(S + 2);
        check("coll_pre_id", 32'({int_out, int_id}), 32'({1'b1, 3'd2}));
        irq_in[2] = 1'b0; wait_cyc(4);
        irq_in[2] = 1'b1;
        wait_cyc(S - 1);
        pulse_ack(); wait_cyc(2);
        check("coll_kept", 32'({int_out, int_id}), 32'({1'b1, 3'd2}));
        pulse_ack(); wait_cyc(2);
        check("coll_cleared", 32'(int_out), 32'd0);
        irq_in[2] = 1'b0;

        // level channel 0 (active low)
        irq_in[0] = 1'b0; wait_cyc(S + 3);
        for (int i = 0; i < 4; i++) begin
            pulse_ack(); wait_cyc(1);
            check("level_hold", 32'({int_out, int_id}), 32'({1'b1, 3'd0}));
        end
        irq_in[0] = 1'b1;
        wait_cyc(S + 1);
        check("level_drop_pre", 32'(int_out), 32'd1);
        wait_cyc(1);
        check("level_drop", 32'(int_out), 32'd0);

        // software raise / clear
        write_reg(2'd3, 32'h10); wait_cyc(2);
        read_reg(2'd2, rd);
        check("status_raise", rd, 32'h8000_0004);
        write_reg(2'd0, 32'h10); wait_cyc(2);
        read_reg(2'd2, rd);
        check("status_clear", rd, 32'h0);

        // async reset mid-request, then recovery of level channel 0
        irq_in[0] = 1'b0; wait_cyc(S + 3);
        read_reg(2'd1, rd);
        check("enable_rb", rd, 32'hFF);
        check("pre_reset_req", 32'(int_out), 32'd1);
        #2 nreset = 1'b0;
        #1;
        check("async_int_out", 32'(int_out), 32'd0);
        check("async_int_id", 32'(int_id), 32'd0);
        check("async_rdata", rdata, 32'd0);
        wait_cyc(3);
        nreset = 1'b1;
        wait_cyc(S + 1);
        read_reg(2'd0, rd);
        check("reset_repend", rd, 32'h01);

        // randomized traffic
        write_reg(2'd1, $urandom_range(0, 255));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) irq_in[$urandom_range(0, N - 1)] ^= 1'b1;
            ack = int_out && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                sel = 1'b1; we = $urandom_range(0, 1) == 1;
                addr = 2'($urandom_range(0, 3)); wdata = $urandom;
            end else begin
                sel = 1'b0; we = 1'b0; wdata = '0;
            end
            @(negedge clk);
        end
        sel = 1'b0; we = 1'b0; ack = 1'b0;
        wait_cyc(3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
